// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port character/attribute RAM between
// the display fetch path and a buffered host read/write port.
//
// Ports:
//   clk, reset (async, active-low)
//   clk_load_char, xtext, ytext   display fetch strobe and text position
//   char_data, char_valid         fetched cell and its one-cycle update pulse
//   host_valid/ready/we/addr/wdata host request port (FIFO buffered)
//   host_rvalid, host_rdata       host read response
//   addr_err                      sticky out-of-range host address flag
//   ram_addr/we/wdata, ram_rdata  registered RAM port, 1-cycle read latency
//
// Build option: define TEXT_RAM_HOST_READ_EN to enable host reads. Without
// it every host entry is a write and the read response port is tied to 0.
module text_ram_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int TEXT_COLS   = 100,
    parameter int TEXT_CELLS  = 6000,
    parameter int FIFO_DEPTH  = 4,
    parameter int XTEXT_WIDTH = 7,
    parameter int YTEXT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_load_char,
    input  logic [XTEXT_WIDTH-1:0] xtext,
    input  logic [YTEXT_WIDTH-1:0] ytext,
    output logic [DATA_WIDTH-1:0]  char_data,
    output logic                   char_valid,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic                   host_we,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0]  host_wdata,
    output logic                   host_rvalid,
    output logic [DATA_WIDTH-1:0]  host_rdata,
    output logic                   addr_err,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_we,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    input  logic [DATA_WIDTH-1:0]  ram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [ADDR_WIDTH:0] CELLS_L = (ADDR_WIDTH+1)'(TEXT_CELLS);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISP,
        S_HOST
    } slot_e;

    // state is the slot currently on the RAM port; it doubles as the
    // first stage of the display read-data tag pipeline.
    slot_e state;
    logic  disp_t1;

    logic [ADDR_WIDTH-1:0] disp_addr;
    assign disp_addr = ADDR_WIDTH'(ytext) * ADDR_WIDTH'(TEXT_COLS)
                     + ADDR_WIDTH'(xtext);

    // Host request FIFO
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_next;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  head_we;
    logic                  head_bad;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    assign empty      = (level == '0);
    assign push       = host_valid && host_ready;
    // Display always wins; the head entry simply waits for the next slot.
    assign pop        = !clk_load_char && !empty;
    assign level_next = level + LW'(push) - LW'(pop);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_wdata[rd_ptr];
    assign head_bad   = ({1'b0, head_addr} >= CELLS_L);

`ifdef TEXT_RAM_HOST_READ_EN
    logic fifo_we [FIFO_DEPTH];
    logic host_t0;
    logic host_t1;

    assign head_we = fifo_we[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr] <= host_we;
        end
    end
`else
    logic unused_host_we;
    assign unused_host_we = host_we;
    assign head_we        = 1'b1;
    assign host_rvalid    = 1'b0;
    assign host_rdata     = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= host_addr;
            fifo_wdata[wr_ptr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            host_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level      <= level_next;
            host_ready <= (level_next != DEPTH_L);
        end
    end

    // Slot FSM, RAM port and read-data steering
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            disp_t1    <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            char_data  <= '0;
            char_valid <= 1'b0;
            addr_err   <= 1'b0;
`ifdef TEXT_RAM_HOST_READ_EN
            host_t0     <= 1'b0;
            host_t1     <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
`endif
        end else begin
            ram_we     <= 1'b0;
            char_valid <= 1'b0;
            disp_t1    <= (state == S_DISP);

            if (clk_load_char) begin
                state    <= S_DISP;
                ram_addr <= disp_addr;
            end else if (!empty) begin
                state <= S_HOST;
                // Bad addresses are consumed without touching the RAM.
                if (head_bad) begin
                    addr_err <= 1'b1;
                end else begin
                    ram_addr <= head_addr;
                    if (head_we) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= head_wdata;
                    end
                end
            end else begin
                state <= S_IDLE;
            end

            if (disp_t1) begin
                char_data  <= ram_rdata;
                char_valid <= 1'b1;
            end

`ifdef TEXT_RAM_HOST_READ_EN
            host_t0     <= pop && !head_bad && !head_we;
            host_t1     <= host_t0;
            host_rvalid <= host_t1;
            if (host_t1) begin
                host_rdata <= ram_rdata;
            end
`endif
        end
    end

endmodule
